mac4_acc: RTL and testbench



---
 rtl/mac4_acc.sv | 131 +++++++++++++
 tb/tb_mac4_acc.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mac4_acc.sv
// Multiply-accumulate stage: sums N_TERMS 4x4 products behind valid/ready handshakes.
// Define MAC4_ACC_SAT_EN to clamp the accumulator at all-ones instead of wrapping.

module mul4x4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);
  // Shift-and-add array: one partial-product row per multiplier bit.
  always_comb begin
    // NOTE: p_o gets a value on every path before it is read, so no latch is inferred.
    p_o = '0;
    for (int i = 0; i < 4; i++) begin
      if (b_i[i]) p_o = p_o + (8'(a_i) << i);
    end
  end
endmodule

module mac4_acc #(
  parameter int ACC_W   = 16,
  parameter int N_TERMS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       x,
  input  logic [3:0]       y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf
);
  typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             op_vld_q, op_vld_d;
  logic             p_vld_q, p_vld_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [3:0]       x_q, y_q;
  logic [7:0]       prod, prod_q;
  logic [ACC_W:0]   sum;
  logic             accept;

  mul4x4 u_mul (.a_i(x_q), .b_i(y_q), .p_o(prod));

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;
  assign accept    = in_valid && in_ready;
  assign sum       = {1'b0, acc_q} + (ACC_W+1)'(prod_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_vld_d = accept;
    p_vld_d  = op_vld_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;

    if (p_vld_q) begin
      ovf_d = ovf_q | sum[ACC_W];
`ifdef MAC4_ACC_SAT_EN
      acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
      acc_d = sum[ACC_W-1:0];
`endif
    end

    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(N_TERMS - 1)) state_d = DRAIN;
        end
      end
      // With the operand stage empty, the product register's last term lands this edge.
      DRAIN: if (!op_vld_q) state_d = DONE;
      DONE: begin
        if (out_ready) begin
          state_d = ACCUM;
          cnt_d   = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase

    if (clr) begin
      state_d  = ACCUM;
      cnt_d    = '0;
      op_vld_d = 1'b0;
      p_vld_d  = 1'b0;
      acc_d    = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q  <= ACCUM;
      cnt_q    <= '0;
      op_vld_q <= 1'b0;
      p_vld_q  <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_vld_q <= op_vld_d;
      p_vld_q  <= p_vld_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: pure data registers carry no reset; their valid bits decide whether they are used.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_q <= x;
      y_q <= y;
    end
    if (op_vld_q) prod_q <= prod;
  end
endmodule

// File: tb/tb_mac4_acc.sv
// Directed bench for mac4_acc: default instance (16-bit, 8 terms) plus an 8-bit, 2-term instance.
// Overflow expectations follow MAC4_ACC_SAT_EN.

module tb_mac4_acc;
  logic        clk = 1'b0;
  logic        rst, clr;
  logic        in_valid, in_ready, out_valid, out_ready, ovf;
  logic [3:0]  x, y;
  logic [15:0] acc_out;
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, ovf_b;
  logic [3:0]  x_b, y_b;
  logic [7:0]  acc_out_b;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc;

  always #5 clk = ~clk;

  mac4_acc #(.ACC_W(16), .N_TERMS(8)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .ovf(ovf)
  );

  mac4_acc #(.ACC_W(8), .N_TERMS(2)) dut_b (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .x(x_b), .y(y_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .acc_out(acc_out_b), .ovf(ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at the negedge right after the last accept edge; cyc=3 means out_valid rose after edge k+2.
  task automatic wait_out(output int c);
    c = 1;
    while (!out_valid && c < 12) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic feed(input int n, input logic [3:0] xv, input logic [3:0] yv);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1; x = xv; y = yv;
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    in_valid = 1'b0; x = '0; y = '0; out_ready = 1'b0;
    in_valid_b = 1'b0; x_b = '0; y_b = '0; out_ready_b = 1'b0;
    #12 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_acc", acc_out, 0);
    check("rst_ovf", ovf, 0);

    // Full-scale sum: 8 x (15*15) = 1800
    feed(8, 4'd15, 4'd15);
    @(negedge clk); in_valid = 1'b0;
    check("full_in_ready_drain", in_ready, 0);
    wait_out(cyc);
    check("full_latency", cyc, 3);
    check("full_out_valid", out_valid, 1);
    check("full_acc", acc_out, 1800);
    check("full_ovf", ovf, 0);

    // Backpressure: result held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_acc", acc_out, 1800);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    check("hand_in_ready", in_ready, 1);
    check("hand_out_valid", out_valid, 0);
    check("hand_acc_clear", acc_out, 0);

    // Bubbles and zeros: sum 3*(0..7) = 84, out_ready already high when out_valid rises
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0); x = 4'(i / 2); y = 4'd3;
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    wait_out(cyc);
    check("bub_out_valid", out_valid, 1);
    check("bub_acc", acc_out, 84);
    check("bub_ovf", ovf, 0);
    @(negedge clk);
    check("bub_same_cycle_hand", in_ready, 1);
    check("bub_out_valid_low", out_valid, 0);
    out_ready = 1'b0;

    // Overflow on the 8-bit, 2-term instance: 225 + 225 = 450
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid_b = 1'b1; x_b = 4'd15; y_b = 4'd15;
    end
    @(negedge clk); in_valid_b = 1'b0;
    for (int i = 0; i < 8 && !out_valid_b; i++) @(negedge clk);
    check("ovf_out_valid", out_valid_b, 1);
`ifdef MAC4_ACC_SAT_EN
    check("ovf_acc_sat", acc_out_b, 255);
`else
    check("ovf_acc_wrap", acc_out_b, 194);
`endif
    check("ovf_flag", ovf_b, 1);
    out_ready_b = 1'b1;
    @(negedge clk); out_ready_b = 1'b0;
    check("ovf_hand_clear", ovf_b, 0);

    // Abort after 5 of 8 terms; operand offered with clr is dropped
    feed(5, 4'd15, 4'd15);
    @(negedge clk); clr = 1'b1; in_valid = 1'b1; x = 4'd15; y = 4'd15;
    @(negedge clk); clr = 1'b0; in_valid = 1'b0;
    check("clr_acc", acc_out, 0);
    check("clr_in_ready", in_ready, 1);
    check("clr_ovf", ovf, 0);
    @(negedge clk);
    check("clr_no_leak", acc_out, 0);
    feed(8, 4'd2, 4'd3);
    @(negedge clk); in_valid = 1'b0;
    wait_out(cyc);
    check("clr_fresh_latency", cyc, 3);
    check("clr_fresh_acc", acc_out, 48);
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;

    // Async reset in DRAIN, between clock edges
    feed(8, 4'd1, 4'd1);
    @(negedge clk); in_valid = 1'b0;
    check("ar_in_drain", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_acc", acc_out, 0);
    check("ar_ovf", ovf, 0);
    check("ar_in_ready", in_ready, 1);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("ar_stays_idle", out_valid, 0);
    check("ar_acc_after", acc_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
